// File: rtl/reset_sequencer.sv
// reset_sequencer: conditions the soft-reset switch (2-flop sync + debounce),
// then releases per-subsystem active-high resets one at a time, each release
// gated by that stage's ready handshake or a per-stage timeout.
module reset_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  soft_rst_raw,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  sys_ready,
  output logic [NUM_STAGES-1:0] timeout_err
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state, nstate;
  logic [CNT_W-1:0]      cnt, ncnt;
  logic [IDX_W-1:0]      idx, nidx;
  logic [NUM_STAGES-1:0] to_set;
  logic [NUM_STAGES-1:0] rst_d, terr_d;
  logic                  rdy_d;

  logic                  s1, s2, db;
  logic [DB_W-1:0]       dcnt;
  logic                  db_flip, db_rise;

  // The debounced level flips on the edge that would complete the run of
  // DEBOUNCE_CYCLES consecutive mismatches.
  assign db_flip = (s2 != db) && (dcnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign db_rise = db_flip && !db;

  // Switch synchronizer and debounce counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= soft_rst_raw;
      s2 <= s1;
      if (s2 != db) begin
        if (db_flip) begin
          db   <= ~db;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  // Sequencer state register; outputs are registered from next-state values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      sys_ready   <= 1'b0;
      timeout_err <= '0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      idx         <= nidx;
      rst_out     <= rst_d;
      sys_ready   <= rdy_d;
      timeout_err <= terr_d;
    end
  end

  // Next-state logic: hold, staged release with ready/timeout, run.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = idx;
    to_set = '0;
    case (state)
      ST_ASSERT: begin
        if (db) begin
          ncnt = '0;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          nstate = ST_RELEASE;
          nidx   = '0;
          ncnt   = '0;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stage_ready[idx] || (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          // ready wins over a coincident timeout
          if (!stage_ready[idx]) to_set[idx] = 1'b1;
          ncnt = '0;
          if (idx == IDX_W'(NUM_STAGES - 1)) nstate = ST_RUN;
          else                               nidx   = idx + 1'b1;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      ST_RUN: ;
      default: nstate = ST_ASSERT;
    endcase
    // a debounced switch press restarts everything from any state
    if (db_rise) begin
      nstate = ST_ASSERT;
      ncnt   = '0;
      nidx   = '0;
      to_set = '0;
    end
  end

  // Output values matching the next state, captured by the state register.
  always_comb begin
    rst_d = '1;
    for (int j = 0; j < NUM_STAGES; j++) begin
      rst_d[j] = (nstate == ST_ASSERT) || ((nstate == ST_RELEASE) && (j > int'(nidx)));
    end
    rdy_d  = (nstate == ST_RUN);
    terr_d = db_rise ? '0 : (timeout_err | to_set);
  end

endmodule
